// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg : shared defaults and the entry record for the reorder buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = 3;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_REG_W-1:0]  dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_entry.sv
// ---------------------------------------------------------------------------
// rob_entry : storage for one reorder-buffer slot (busy/done/dest/data)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rob_entry
  import rob_pkg::*;
#(
  parameter int REG_W  = ROB_REG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              alloc_we,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              commit_clr,
  output logic              done,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] data
);

  logic busy;
  logic wb_hit;

  // A late writeback aimed at a freed slot must not resurrect it.
  assign wb_hit = wb_we && busy;

  always_ff @(posedge clk) begin
    if (clr) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (alloc_we) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if (commit_clr) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (wb_hit) begin
      done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_we) begin
      dest <= alloc_dest;
    end
    if (wb_hit) begin
      data <= wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rob_commit.sv
// ---------------------------------------------------------------------------
// rob_commit : in-order commit reorder buffer with flush and occupancy flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rob_commit
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = TAG_W + 1;

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  done_vec;
  logic [REG_W-1:0]  dest_arr [DEPTH];
  logic [DATA_W-1:0] data_arr [DEPTH];
  logic              wipe;
  logic              alloc_fire;
  logic              commit_fire;

  assign wipe         = clr || flush;
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign alloc_ready  = !full;
  assign alloc_tag    = tail;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign commit_valid = !empty && done_vec[head];
  assign commit_fire  = commit_valid && commit_ready;

  // Gate the head view so stale slot contents never appear after reset.
  assign commit_dest = commit_valid ? dest_arr[head] : '0;
  assign commit_data = commit_valid ? data_arr[head] : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    rob_entry #(
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
    ) u_entry (
      .clk        (clk),
      .clr        (wipe),
      .alloc_we   (alloc_fire && (tail == TAG_W'(i))),
      .alloc_dest (alloc_dest),
      .wb_we      (wb_valid && (wb_tag == TAG_W'(i))),
      .wb_data    (wb_data),
      .commit_clr (commit_fire && (head == TAG_W'(i))),
      .done       (done_vec[i]),
      .dest       (dest_arr[i]),
      .data       (data_arr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      if (commit_fire) begin
        head <= head + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
